// File: rtl/weather_fsm_param.sv
// weather_fsm_param: parametrised month/weather Moore machine with registered
// outputs. Seven month states are driven by snow/rain/cloud flags and a
// temperature sample; a minimum-dwell counter blocks early exits, enable
// gates every transition, and encoding 7 recovers to JANUARY.
// Optional feature macro: WEATHER_FSM_TRANS_CNT_EN adds a saturating count of
// real state changes on trans_cnt (tied to 0 when the macro is undefined).
module weather_fsm_param #(
    parameter int TEMP_W    = 7,
    parameter int T_COLD    = 30,
    parameter int T_WARM    = 50,
    parameter int T_HOT     = 80,
    parameter int MIN_DWELL = 0,
    parameter int CNT_W     = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              snow,
    input  logic              rain,
    input  logic              cloud,
    input  logic [TEMP_W-1:0] temp,
    output logic [2:0]        state_o,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              changed,
    output logic [7:0]        dwell_cnt,
    output logic [CNT_W-1:0]  trans_cnt
);

    typedef enum logic [2:0] {
        ST_JAN = 3'd0,
        ST_FEB = 3'd1,
        ST_MAR = 3'd2,
        ST_APR = 3'd3,
        ST_MAY = 3'd4,
        ST_JUN = 3'd5,
        ST_JUL = 3'd6,
        ST_ILL = 3'd7
    } state_t;

    localparam logic [TEMP_W-1:0] COLD_TH   = TEMP_W'(T_COLD);
    localparam logic [TEMP_W-1:0] WARM_TH   = TEMP_W'(T_WARM);
    localparam logic [TEMP_W-1:0] HOT_TH    = TEMP_W'(T_HOT);
    localparam logic [7:0]        DWELL_MAX = 8'(MIN_DWELL);

    // Registers hold raw encodings so the illegal value 7 is representable.
    logic [2:0] state_q, state_d, cand;
    logic [2:0] abc_q, abc_d;
    logic       changed_q, changed_d;
    logic [7:0] dwell_q, dwell_d;
    logic       move;
    logic       dwell_ok;

    // Candidate next state from the current month and the weather inputs
    always_comb begin
        cand = ST_JAN;
        case (state_q)
            ST_JAN: begin
                if (snow)                cand = (temp > COLD_TH) ? ST_JAN : ST_FEB;
                else if (temp > WARM_TH) cand = ST_JUL;
                else                     cand = ST_JUN;
            end
            ST_FEB: begin
                if (snow)      cand = ST_JAN;
                else if (rain) cand = ST_MAR;
                else           cand = ST_FEB;
            end
            ST_MAR: cand = ST_APR;
            ST_APR: begin
                if (cloud)     cand = rain ? ST_MAY : ST_JAN;
                else if (snow) cand = ST_MAR;
                else           cand = ST_APR;
            end
            ST_MAY: begin
                if (!cloud)    cand = ST_JUN;
                else if (rain) cand = ST_MAR;
                else           cand = ST_JUL;
            end
            ST_JUN: cand = rain ? ST_JUN : ST_JUL;
            ST_JUL: begin
                if (snow)               cand = ST_JAN;
                else if (rain)          cand = ST_MAR;
                else if (temp > HOT_TH) cand = ST_JUL;
                else                    cand = ST_JUN;
            end
            default: cand = ST_JAN;
        endcase
    end

    // Transition gate, dwell update and next-state Moore output decode
    always_comb begin
        // dwell_q never exceeds DWELL_MAX, so equality means "dwell satisfied".
        dwell_ok  = (dwell_q == DWELL_MAX);
        state_d   = state_q;
        if (state_q == ST_ILL)      state_d = ST_JAN;
        else if (enable && dwell_ok) state_d = cand;
        move      = (state_d != state_q);
        changed_d = move;
        if (move)          dwell_d = 8'd0;
        else if (!dwell_ok) dwell_d = dwell_q + 8'd1;
        else               dwell_d = dwell_q;
        case (state_d)
            ST_JAN:  abc_d = 3'b100;
            ST_FEB:  abc_d = 3'b110;
            ST_MAR:  abc_d = 3'b111;
            ST_APR:  abc_d = 3'b011;
            ST_MAY:  abc_d = 3'b110;
            ST_JUN:  abc_d = 3'b110;
            ST_JUL:  abc_d = 3'b010;
            default: abc_d = 3'b000;
        endcase
    end

    // State, registered outputs, change pulse and dwell counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_JAN;
            abc_q     <= 3'b100;
            changed_q <= 1'b0;
            dwell_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            abc_q     <= abc_d;
            changed_q <= changed_d;
            dwell_q   <= dwell_d;
        end
    end

`ifdef WEATHER_FSM_TRANS_CNT_EN
    logic [CNT_W-1:0] trans_q, trans_d;

    // Saturating count of real state changes, recovery included
    always_comb begin
        trans_d = trans_q;
        if (move && (trans_q != {CNT_W{1'b1}})) trans_d = trans_q + CNT_W'(1);
    end

    // Transition counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) trans_q <= '0;
        else          trans_q <= trans_d;
    end

    assign trans_cnt = trans_q;
`else
    assign trans_cnt = '0;
`endif

    assign state_o   = state_q;
    assign {a, b, c} = abc_q;
    assign changed   = changed_q;
    assign dwell_cnt = dwell_q;

endmodule

// File: tb/tb_weather_fsm_param.sv
// Bench for weather_fsm_param: two instances (MIN_DWELL=0 and MIN_DWELL=3,
// both CNT_W=2) share stimulus; a reference model pushes expected outputs
// per cycle and a scoreboard compares them, plus directed scenario checks.
module tb_weather_fsm_param;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable, snow, rain, cloud;
  logic [6:0] temp;

  logic [2:0] st0, st1;
  logic       a0, b0, c0, chg0, a1, b1, c1, chg1;
  logic [7:0] dw0, dw1;
  logic [1:0] tc0, tc1;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef WEATHER_FSM_TRANS_CNT_EN
  localparam bit TC_ON = 1'b1;
`else
  localparam bit TC_ON = 1'b0;
`endif

  // expected word: [16:14] state, [13:11] abc, [10] changed, [9:2] dwell, [1:0] trans
  logic [16:0] exp_q[$];
  logic [16:0] exp_d_q[$];

  logic [2:0] m_st, d_st;
  logic [7:0] m_dw, d_dw;
  logic [1:0] m_tc, d_tc;

  weather_fsm_param #(.MIN_DWELL(0), .CNT_W(2)) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .snow(snow), .rain(rain),
    .cloud(cloud), .temp(temp), .state_o(st0), .a(a0), .b(b0), .c(c0),
    .changed(chg0), .dwell_cnt(dw0), .trans_cnt(tc0)
  );

  weather_fsm_param #(.MIN_DWELL(3), .CNT_W(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .snow(snow), .rain(rain),
    .cloud(cloud), .temp(temp), .state_o(st1), .a(a1), .b(b1), .c(c1),
    .changed(chg1), .dwell_cnt(dw1), .trans_cnt(tc1)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [2:0] cand_of(input logic [2:0] s);
    case (s)
      3'd0: cand_of = snow ? ((temp > 7'd30) ? 3'd0 : 3'd1) : ((temp > 7'd50) ? 3'd6 : 3'd5);
      3'd1: cand_of = snow ? 3'd0 : (rain ? 3'd2 : 3'd1);
      3'd2: cand_of = 3'd3;
      3'd3: cand_of = cloud ? (rain ? 3'd4 : 3'd0) : (snow ? 3'd2 : 3'd3);
      3'd4: cand_of = !cloud ? 3'd5 : (rain ? 3'd2 : 3'd6);
      3'd5: cand_of = rain ? 3'd5 : 3'd6;
      3'd6: cand_of = snow ? 3'd0 : (rain ? 3'd2 : ((temp > 7'd80) ? 3'd6 : 3'd5));
      default: cand_of = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] abc_of(input logic [2:0] s);
    case (s)
      3'd0: abc_of = 3'b100;
      3'd1: abc_of = 3'b110;
      3'd2: abc_of = 3'b111;
      3'd3: abc_of = 3'b011;
      3'd4: abc_of = 3'b110;
      3'd5: abc_of = 3'b110;
      3'd6: abc_of = 3'b010;
      default: abc_of = 3'b000;
    endcase
  endfunction

  function automatic logic [16:0] adv(input logic [2:0] st, input logic [7:0] dw,
                                      input logic [1:0] tc, input logic [7:0] md);
    logic [2:0] nx;
    logic       ch;
    logic [7:0] ndw;
    logic [1:0] ntc;
    if (st == 3'd7)                 nx = 3'd0;
    else if (enable && (dw >= md))  nx = cand_of(st);
    else                            nx = st;
    ch  = (nx != st);
    ndw = ch ? 8'd0 : ((dw < md) ? dw + 8'd1 : dw);
    ntc = (TC_ON && ch && (tc != 2'd3)) ? tc + 2'd1 : (TC_ON ? tc : 2'd0);
    return {nx, abc_of(nx), ch, ndw, ntc};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic sn, input logic rn,
                      input logic cl, input logic [6:0] tp);
    logic [16:0] e;
    enable = en; snow = sn; rain = rn; cloud = cl; temp = tp;
    e = adv(m_st, m_dw, m_tc, 8'd0);
    exp_q.push_back(e);
    m_st = e[16:14]; m_dw = e[9:2]; m_tc = e[1:0];
    e = adv(d_st, d_dw, d_tc, 8'd3);
    exp_d_q.push_back(e);
    d_st = e[16:14]; d_dw = e[9:2]; d_tc = e[1:0];
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    m_st = 3'd0; m_dw = 8'd0; m_tc = 2'd0;
    d_st = 3'd0; d_dw = 8'd0; d_tc = 2'd0;
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clock) begin
    logic [16:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if ({st0, a0, b0, c0, chg0, dw0, tc0} !== e) begin
        tests_failed++;
        $display("FAIL sb_dut0 got %b exp %b", {st0, a0, b0, c0, chg0, dw0, tc0}, e);
      end
    end
    if (exp_d_q.size() > 0) begin
      e = exp_d_q.pop_front();
      tests_run++;
      if ({st1, a1, b1, c1, chg1, dw1, tc1} !== e) begin
        tests_failed++;
        $display("FAIL sb_dut1 got %b exp %b", {st1, a1, b1, c1, chg1, dw1, tc1}, e);
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    apply_reset();
    step(1, 1, 0, 0, 7'd0);   // JAN -> FEB
    step(1, 0, 1, 0, 7'd0);   // FEB -> MARCH
    tests_run++;
    if (st0 !== 3'd2) begin
      tests_failed++; $display("FAIL reach_march got %0d exp 2", st0);
    end
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({st0, a0, b0, c0, chg0, dw0, tc0} !== {3'd0, 3'b100, 1'b0, 8'd0, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_async got %b exp %b", {st0, a0, b0, c0, chg0, dw0, tc0},
               {3'd0, 3'b100, 1'b0, 8'd0, 2'd0});
    end
    @(posedge clock); #1;
    tests_run++;
    if ({st0, a0, b0, c0, chg0, dw0, tc0, st1, dw1} !== {3'd0, 3'b100, 1'b0, 8'd0, 2'd0, 3'd0, 8'd0}) begin
      tests_failed++;
      $display("FAIL reset_held got st0=%0d abc=%b chg=%b dw=%0d tc=%0d st1=%0d dw1=%0d exp 0 100 0 0 0 0 0",
               st0, {a0, b0, c0}, chg0, dw0, tc0, st1, dw1);
    end
    @(negedge clock);
    reset_n = 1'b1;
    m_st = 3'd0; m_dw = 8'd0; m_tc = 2'd0;
    d_st = 3'd0; d_dw = 8'd0; d_tc = 2'd0;
  endtask

  task automatic test_jan_split();
    apply_reset();
    step(1, 1, 0, 0, 7'd31);
    tests_run++;
    if ({st0, chg0} !== {3'd0, 1'b0}) begin
      tests_failed++; $display("FAIL jan_hold_31 got st=%0d chg=%b exp st=0 chg=0", st0, chg0);
    end
    step(1, 1, 0, 0, 7'd30);
    tests_run++;
    if ({st0, a0, b0, c0, chg0} !== {3'd1, 3'b110, 1'b1}) begin
      tests_failed++; $display("FAIL jan_to_feb_30 got st=%0d abc=%b chg=%b exp st=1 abc=110 chg=1",
                               st0, {a0, b0, c0}, chg0);
    end
    step(1, 0, 0, 0, 7'd0);
    tests_run++;
    if ({st0, chg0} !== {3'd1, 1'b0}) begin
      tests_failed++; $display("FAIL feb_pulse_once got st=%0d chg=%b exp st=1 chg=0", st0, chg0);
    end
  endtask

  task automatic test_dwell();
    int g;
    int cnt;
    apply_reset();
    g = 0;
    while (st1 != 3'd1 && g < 20) begin step(1, 1, 0, 0, 7'd0); g++; end
    tests_run++;
    if (st1 !== 3'd1) begin tests_failed++; $display("FAIL dwell_reach_feb got %0d exp 1", st1); end
    g = 0;
    while (st1 != 3'd2 && g < 20) begin step(1, 0, 1, 0, 7'd0); g++; end
    tests_run++;
    if (st1 !== 3'd2) begin tests_failed++; $display("FAIL dwell_reach_mar got %0d exp 2", st1); end
    cnt = 0;
    while (st1 == 3'd2 && cnt < 20) begin cnt++; step(1, 0, 0, 0, 7'd0); end
    tests_run++;
    if (cnt != 4) begin tests_failed++; $display("FAIL dwell_march_cycles got %0d exp 4", cnt); end
    tests_run++;
    if ({st1, a1, b1, c1, chg1} !== {3'd3, 3'b011, 1'b1}) begin
      tests_failed++; $display("FAIL dwell_april got st=%0d abc=%b chg=%b exp st=3 abc=011 chg=1",
                               st1, {a1, b1, c1}, chg1);
    end
  endtask

  task automatic test_enable_freeze();
    int held;
    apply_reset();
    step(1, 0, 0, 0, 7'd60);
    tests_run++;
    if (st0 !== 3'd6) begin tests_failed++; $display("FAIL freeze_enter_july got %0d exp 6", st0); end
    held = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 7'd60);
      if (st0 == 3'd6) held++;
    end
    tests_run++;
    if (held != 10) begin tests_failed++; $display("FAIL freeze_hold got %0d exp 10", held); end
    step(1, 1, 0, 0, 7'd60);
    tests_run++;
    if ({st0, chg0} !== {3'd0, 1'b1}) begin
      tests_failed++; $display("FAIL freeze_release got st=%0d chg=%b exp st=0 chg=1", st0, chg0);
    end
  endtask

  task automatic test_july_boundary();
    apply_reset();
    step(1, 0, 0, 0, 7'd60);
    step(1, 0, 0, 0, 7'd81);
    tests_run++;
    if ({st0, chg0} !== {3'd6, 1'b0}) begin
      tests_failed++; $display("FAIL july_hold_81 got st=%0d chg=%b exp st=6 chg=0", st0, chg0);
    end
    step(1, 0, 0, 0, 7'd80);
    tests_run++;
    if ({st0, a0, b0, c0} !== {3'd5, 3'b110}) begin
      tests_failed++; $display("FAIL july_to_june_80 got st=%0d abc=%b exp st=5 abc=110", st0, {a0, b0, c0});
    end
    step(1, 0, 0, 0, 7'd0);
    tests_run++;
    if ({st0, a0, b0, c0} !== {3'd6, 3'b010}) begin
      tests_failed++; $display("FAIL june_to_july got st=%0d abc=%b exp st=6 abc=010", st0, {a0, b0, c0});
    end
  endtask

  task automatic test_counter();
    logic [3:0] tab_sn, tab_rn, tab_cl;
    int tc_tab[5] = '{1, 2, 3, 3, 3};
    logic [4:0] sn_v = 5'b10001;
    logic [4:0] rn_v = 5'b00010;
    logic [4:0] cl_v = 5'b01000;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, sn_v[i], rn_v[i], cl_v[i], 7'd0);
      tests_run++;
      if ({chg0, tc0} !== {1'b1, (TC_ON ? 2'(tc_tab[i]) : 2'd0)}) begin
        tests_failed++;
        $display("FAIL trans_cnt_%0d got chg=%b tc=%0d exp chg=1 tc=%0d", i, chg0, tc0,
                 TC_ON ? tc_tab[i] : 0);
      end
    end
    force dut0.state_q = 3'd7;
    #1 release dut0.state_q;
    m_st = 3'd7;
    step(1, 1, 0, 0, 7'd0);
    tests_run++;
    if ({st0, a0, b0, c0, chg0, dw0, tc0} !== {3'd0, 3'b100, 1'b1, 8'd0, (TC_ON ? 2'd3 : 2'd0)}) begin
      tests_failed++;
      $display("FAIL illegal_recover got st=%0d abc=%b chg=%b dw=%0d tc=%0d exp st=0 abc=100 chg=1 dw=0 tc=%0d",
               st0, {a0, b0, c0}, chg0, dw0, tc0, TC_ON ? 3 : 0);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0; snow = 1'b0; rain = 1'b0; cloud = 1'b0; temp = 7'd0;
    m_st = 3'd0; m_dw = 8'd0; m_tc = 2'd0;
    d_st = 3'd0; d_dw = 8'd0; d_tc = 2'd0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    test_reset();
    test_jan_split();
    test_dwell();
    test_enable_freeze();
    test_july_boundary();
    test_counter();
    test_random();
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
